// File: rtl/dump_pkg.sv
// Shared types and default sizes for the register-file dump sequencer.
package dump_pkg;

    localparam int unsigned DEF_NUM_REGS   = 32;
    localparam int unsigned DEF_ADDR_W     = 5;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned BYTES_PER_WORD = DEF_DATA_W / 8;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StSend,
        StCsum,
        StFin
    } state_e;

    // Counter width that never collapses to zero bits for single-byte words.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Loadable MSB-first byte serializer with a valid/ready holding register.
// A load captures a full word and raises valid until its last byte is accepted.
module word_serializer
    import dump_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              tx_ready_i,
    output logic [7:0]        byte_o,
    output logic              valid_o,
    output logic              accept_o,
    output logic              last_o
);

    localparam int unsigned BytesPerWord = DATA_W / 8;
    localparam int unsigned CntW         = cnt_width(BytesPerWord);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;

    assign byte_o   = shift_q[DATA_W-1 -: 8];
    assign valid_o  = valid_q;
    assign accept_o = valid_q & tx_ready_i;
    assign last_o   = (cnt_q == '0);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = word_i;
            cnt_d   = CntW'(BytesPerWord - 1);
            valid_d = 1'b1;
        end else if (accept_o) begin
            shift_d = shift_q << 8;
            if (last_o) begin
                valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Streams every register-file word out as bytes via the debug read port.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte after the last register.
module regfile_dump_reader
    import dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              dbg_on_o,
    output logic [ADDR_W-1:0] dbg_addr_o,
    input  logic [DATA_W-1:0] dbg_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dbg_on_q, dbg_on_d;
    logic              load;
    logic [7:0]        ser_byte;
    logic              ser_valid, ser_accept, ser_last;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    word_serializer #(
        .DATA_W(DATA_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .word_i    (dbg_data_i),
        .tx_ready_i(tx_ready_i),
        .byte_o    (ser_byte),
        .valid_o   (ser_valid),
        .accept_o  (ser_accept),
        .last_o    (ser_last)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dbg_on_d = dbg_on_q;
        load     = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StAddr;
                    addr_d   = '0;
                    dbg_on_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            StAddr: begin
                load    = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (ser_accept) begin
`ifdef DUMP_CHECKSUM_EN
                    csum_d = csum_q ^ ser_byte;
`endif
                    if (ser_last) begin
                        if (addr_q < LastAddr) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = StAddr;
                        end else begin
`ifdef DUMP_CHECKSUM_EN
                            state_d  = StCsum;
`else
                            state_d  = StFin;
                            dbg_on_d = 1'b0;
`endif
                        end
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            // tx_valid is held high by the state itself, so ready alone completes it.
            StCsum: begin
                if (tx_ready_i) begin
                    state_d  = StFin;
                    dbg_on_d = 1'b0;
                end
            end
`endif
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            dbg_on_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            dbg_on_q <= dbg_on_d;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign tx_valid_o = ser_valid | (state_q == StCsum);
    assign tx_data_o  = (state_q == StCsum) ? csum_q : ser_byte;
`else
    assign tx_valid_o = ser_valid;
    assign tx_data_o  = ser_byte;
`endif

    assign dbg_on_o   = dbg_on_q;
    assign dbg_addr_o = addr_q;
    assign busy_o     = (state_q != StIdle) && (state_q != StFin);
    assign done_o     = (state_q == StFin);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected byte streams are built from a
// register model, captured handshakes are popped and compared per scenario.
module tb_regfile_dump_reader;

`ifdef DUMP_CHECKSUM_EN
    localparam int NBytes  = 129;
    localparam int DoneCyc = 161;
`else
    localparam int NBytes  = 128;
    localparam int DoneCyc = 160;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dbg_on;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    logic [31:0] regs[32];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          t0      = 0;
    int          done_cnt = 0;
    int          stab_err = 0;

    regfile_dump_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .dbg_on_o  (dbg_on),
        .dbg_addr_o(dbg_addr),
        .dbg_data_i(dbg_data),
        .tx_data_o (tx_data),
        .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready),
        .busy_o    (busy),
        .done_o    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file debug port updates on the falling edge.
    always @(negedge clk) if (dbg_on) dbg_data <= regs[dbg_addr];

    // Capture accepted bytes, done pulses and handshake-hold violations.
    initial begin : monitor
        logic       prev_hold;
        logic [7:0] prev_data;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && (!tx_valid || tx_data != prev_data)) stab_err++;
                prev_hold = tx_valid && !tx_ready;
                prev_data = tx_data;
                if (tx_valid && tx_ready) got_q.push_back(tx_data);
                if (done) done_cnt++;
            end
        end
    end

    task automatic load_default();
        for (int i = 0; i < 32; i++) regs[i] = {8'hA5, 8'(i), 8'h5A, 8'(i * 3)};
        regs[0]  = 32'h0000_0001;
        regs[31] = 32'h0000_002A;
    endtask

    task automatic push_expected();
        logic [7:0] x;
        x = '0;
        exp_q.delete();
        for (int r = 0; r < 32; r++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(regs[r][8*b +: 8]);
                x = x ^ regs[r][8*b +: 8];
            end
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input bit rnd, input int restart_at, input int budget,
                             output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                cycles = cyc - t0;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) tx_ready = ($urandom_range(0, 99) < 30);
            start = (restart_at >= 0) && (cyc - t0 == restart_at);
        end
        start = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_tests += 6;
        if (dbg_on !== 1'b0) begin n_fail++; $display("FAIL reset_dbg_on: got %b expected 0", dbg_on); end
        if (dbg_addr !== 5'd0) begin n_fail++; $display("FAIL reset_dbg_addr: got %0d expected 0", dbg_addr); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %02h expected 00", tx_data); end
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit         ok;
        int         cycles;
        int         gaps;
        logic [7:0] first_exp[4];
        logic [7:0] last_exp[4];
        logic [7:0] e;
        logic [7:0] g;
        first_exp = '{8'h00, 8'h00, 8'h00, 8'h01};
        last_exp  = '{8'h00, 8'h00, 8'h00, 8'h2A};
        load_default();
        push_expected();
        got_q.delete();
        done_cnt = 0;
        gaps = 0;
        pulse_start();
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                cycles = cyc - t0;
                n_tests++;
                if (dbg_on !== 1'b0) begin n_fail++; $display("FAIL basic_dbg_on_fin: got %b expected 0", dbg_on); end
                break;
            end
            if (dbg_on !== 1'b1) gaps++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests += 4;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
        if (cycles != DoneCyc) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", cycles, DoneCyc); end
        if (gaps != 0) begin n_fail++; $display("FAIL basic_dbg_on_gap: got %0d low cycles expected 0", gaps); end
        if (got_q.size() != NBytes) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), NBytes); end
        if (got_q.size() >= 128) begin
            for (int i = 0; i < 4; i++) begin
                n_tests += 2;
                if (got_q[i] !== first_exp[i]) begin n_fail++; $display("FAIL basic_first[%0d]: got %02h expected %02h", i, got_q[i], first_exp[i]); end
                if (got_q[124+i] !== last_exp[i]) begin n_fail++; $display("FAIL basic_last[%0d]: got %02h expected %02h", i, got_q[124+i], last_exp[i]); end
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL basic_byte: got %02h expected %02h", g, e); end
        end
    endtask

    task automatic test_stalls();
        bit         ok;
        int         cycles;
        int         err0;
        logic [7:0] e;
        logic [7:0] g;
        load_default();
        push_expected();
        got_q.delete();
        done_cnt = 0;
        err0 = stab_err;
        tx_ready = 1'b0;
        pulse_start();
        wait_done(1'b1, -1, 3000, ok, cycles);
        n_tests += 4;
        if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no done expected done"); end
        if (got_q.size() != NBytes) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", got_q.size(), NBytes); end
        if (stab_err != err0) begin n_fail++; $display("FAIL stall_hold: got %0d violations expected 0", stab_err - err0); end
        if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done_cnt: got %0d expected 1", done_cnt); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL stall_byte: got %02h expected %02h", g, e); end
        end
    endtask

`ifdef DUMP_CHECKSUM_EN
    task automatic test_checksum();
        bit ok;
        int cycles;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[0] = 32'h0102_0304;
        got_q.delete();
        done_cnt = 0;
        pulse_start();
        wait_done(1'b0, -1, 400, ok, cycles);
        n_tests += 3;
        if (got_q.size() != 129) begin n_fail++; $display("FAIL csum_count: got %0d expected 129", got_q.size()); end
        if (got_q.size() == 129 && got_q[128] !== 8'h04) begin n_fail++; $display("FAIL csum_byte: got %02h expected 04", got_q[128]); end
        if (!ok || cycles != 161) begin n_fail++; $display("FAIL csum_done_cycle: got %0d expected 161", cycles); end
    endtask
`endif

    task automatic test_restart_ignored();
        bit         ok;
        int         cycles;
        logic [7:0] e;
        logic [7:0] g;
        load_default();
        push_expected();
        got_q.delete();
        done_cnt = 0;
        pulse_start();
        wait_done(1'b0, 50, 400, ok, cycles);
        repeat (10) @(posedge clk);
        #1;
        n_tests += 4;
        if (!ok || cycles != DoneCyc) begin n_fail++; $display("FAIL restart_done_cycle: got %0d expected %0d", cycles, DoneCyc); end
        if (got_q.size() != NBytes) begin n_fail++; $display("FAIL restart_count: got %0d expected %0d", got_q.size(), NBytes); end
        if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done_cnt: got %0d expected 1", done_cnt); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_busy_after: got %b expected 0", busy); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL restart_byte: got %02h expected %02h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        bit         ok;
        int         cycles;
        bit         reached;
        logic [7:0] e;
        logic [7:0] g;
        load_default();
        push_expected();
        got_q.delete();
        done_cnt = 0;
        reached = 1'b0;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            if (got_q.size() == 30) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        #1;
        rst = 1'b1;
        #1;
        n_tests += 4;
        if (!reached) begin n_fail++; $display("FAIL rstmid_reach: got %0d bytes expected 30", got_q.size()); end
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_valid: got %b expected 0", tx_valid); end
        if (dbg_on !== 1'b0) begin n_fail++; $display("FAIL rstmid_dbg_on: got %b expected 0", dbg_on); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        got_q.delete();
        done_cnt = 0;
        pulse_start();
        n_tests++;
        if (dbg_addr !== 5'd0) begin n_fail++; $display("FAIL rstmid_restart_addr: got %0d expected 0", dbg_addr); end
        wait_done(1'b0, -1, 400, ok, cycles);
        n_tests += 2;
        if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got no done expected done"); end
        if (got_q.size() != NBytes) begin n_fail++; $display("FAIL rstmid_count: got %0d expected %0d", got_q.size(), NBytes); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL rstmid_byte: got %02h expected %02h", g, e); end
        end
    endtask

    task automatic test_long_stall();
        bit         ok;
        int         cycles;
        int         bad_addr, bad_data, bad_valid, bad_done;
        logic [7:0] e;
        logic [7:0] g;
        load_default();
        push_expected();
        got_q.delete();
        done_cnt = 0;
        bad_addr = 0;
        bad_data = 0;
        bad_valid = 0;
        bad_done = 0;
        tx_ready = 1'b0;
        pulse_start();
        @(posedge clk);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (dbg_addr !== 5'd0) bad_addr++;
            if (tx_data !== 8'h00) bad_data++;
            if (tx_valid !== 1'b1) bad_valid++;
            if (done !== 1'b0) bad_done++;
        end
        n_tests += 4;
        if (bad_addr != 0) begin n_fail++; $display("FAIL lstall_addr: got %0d bad cycles expected 0", bad_addr); end
        if (bad_data != 0) begin n_fail++; $display("FAIL lstall_data: got %0d bad cycles expected 0", bad_data); end
        if (bad_valid != 0) begin n_fail++; $display("FAIL lstall_valid: got %0d bad cycles expected 0", bad_valid); end
        if (bad_done != 0) begin n_fail++; $display("FAIL lstall_done: got %0d bad cycles expected 0", bad_done); end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_done(1'b0, -1, 400, ok, cycles);
        n_tests += 2;
        if (!ok) begin n_fail++; $display("FAIL lstall_timeout: got no done expected done"); end
        if (got_q.size() != NBytes) begin n_fail++; $display("FAIL lstall_count: got %0d expected %0d", got_q.size(), NBytes); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_tests++;
            if (g !== e) begin n_fail++; $display("FAIL lstall_byte: got %02h expected %02h", g, e); end
        end
    endtask

    initial begin
        load_default();
        test_reset();
        test_basic();
        test_stalls();
`ifdef DUMP_CHECKSUM_EN
        test_checksum();
`endif
        test_restart_ignored();
        test_reset_mid();
        test_long_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug-path sequencer that reads the whole CPU register file through its debug read port and streams the contents out as bytes. It sits between the register file's debug port (`Debug_on`, `read_regDebug`, `out_regDebug`) and the byte transmitter of the debug UART. A single `start` pulse dumps all registers in ascending address order, most-significant byte first, using a valid/ready byte handshake.

## Interface
- `NUM_REGS`, default 32: number of registers dumped, addresses 0..NUM_REGS-1.
- `ADDR_W`, default 5: width of the debug address.
- `DATA_W`, default 32: register width; must be a multiple of 8.
- `clk`, input, 1: clock. Reset is `rst`, asynchronous, active-high; the clock is `clk`.
- `rst`, input, 1: asynchronous active-high reset.
- `start`, input, 1: request a dump; sampled only in IDLE.
- `dbg_on`, output, 1: drives register file `Debug_on`.
- `dbg_addr`, output, ADDR_W: drives register file `read_regDebug`.
- `dbg_data`, input, DATA_W: from register file `out_regDebug`; the register file updates it on the falling clock edge.
- `tx_data`, output, 8: byte to transmit.
- `tx_valid`, output, 1: `tx_data` is valid.
- `tx_ready`, input, 1: transmitter accepts the byte.
- `busy`, output, 1: a dump is in progress.
- `done`, output, 1: one-cycle pulse when the dump completes.

## Operation
- States:
  - IDLE: waiting for `start`.
  - ADDR: address presented; the word is captured at the next rising edge.
  - SEND: shifting out bytes.
  - CSUM: checksum byte, present only with the macro defined.
  - FIN: dump complete.
- IDLE -> ADDR on `start`=1. Set `dbg_on`=1, `dbg_addr`=0, `busy`=1, and clear the checksum.
- ADDR -> SEND after exactly 1 cycle. Capture `dbg_data` into the shift register, set byte counter = DATA_W/8-1, assert `tx_valid`.
- SEND: `tx_data` = shift register [DATA_W-1 -: 8].
  - On `tx_valid && tx_ready`: shift left 8 and XOR the byte into the checksum.
  - If that was the last byte of the word and `dbg_addr` < NUM_REGS-1: increment `dbg_addr`, go to ADDR, drop `tx_valid`.
  - If it was the last byte of the word and `dbg_addr` = NUM_REGS-1: go to CSUM with the macro, otherwise to FIN.
- CSUM: `tx_data` = checksum, `tx_valid`=1. On handshake go to FIN.
- FIN: `done`=1 for one cycle, `dbg_on`=0, `busy`=0, then go to IDLE.
- `dbg_on` stays high from the ADDR entry through the last handshake. It is never toggled between words.
- `start` while `busy`=1 is ignored. It is not queued.
- Handshake rules:
  - Once `tx_valid` is asserted, `tx_data` and `tx_valid` stay stable until the handshake completes.
  - `tx_valid` never depends combinationally on `tx_ready`.
- `tx_ready` may be low for any number of cycles. The dump stalls with no data loss, and `dbg_addr` is held.
- Address never wraps past NUM_REGS-1. No register is read twice per dump.
- Reset values: `dbg_on`=0, `dbg_addr`=0, `tx_data`=0x00, `tx_valid`=0, `busy`=0, `done`=0, state IDLE.
- Reset mid-dump aborts immediately and asynchronously. Any partially sent word is discarded. `start` after reset restarts from address 0.

## Timing
- `start` is sampled at edge E0. `dbg_on`/`dbg_addr` become valid after E0. The register file updates `dbg_data` on the falling edge between E0 and E1. The capture occurs at E1, and `tx_valid` is high after E1.
- Per word with `tx_ready` tied high: 1 ADDR cycle + DATA_W/8 SEND cycles.
- Full dump with defaults: 160 cycles, or 161 with the checksum.
- `done` is high in the cycle after the final handshake.

## Configuration
- Macro `DUMP_CHECKSUM_EN`.
- Defined: after the last register byte, one extra byte is sent, the XOR of all NUM_REGS*DATA_W/8 data bytes; CSUM state is present.
- Undefined: CSUM state and the checksum register are absent; FIN follows the last data byte directly.

## Structure
- Package `dump_pkg`:
  - state enum (IDLE, ADDR, SEND, CSUM, FIN)
  - `BYTES_PER_WORD` = DATA_W/8
  - default NUM_REGS/ADDR_W/DATA_W constants
- Sub-module `word_serializer`: the loadable MSB-first shift register, byte counter and valid/ready holding logic. The top FSM owns the address, checksum and `done`.

## Test plan
- Register model preloaded with r0=0x00000001 and r31=0x0000002A; `tx_ready`=1; `start` pulse:
  - First bytes 00 00 00 01, last bytes 00 00 00 2A.
  - 128 bytes in total, `done` at cycle 160.
  - `dbg_on` continuously high from cycle 1 through the last byte.
- Random `tx_ready` stalls (high 30% of cycles): byte stream identical to the previous scenario; `tx_data` stable while `tx_valid`=1 and `tx_ready`=0.
- `DUMP_CHECKSUM_EN` defined; r0=0x01020304, all other registers 0: byte 129 = 0x04; `done` follows its handshake.
- `start` re-pulsed at cycle 50 of a dump: ignored; still exactly 128 bytes and a single `done` pulse.
- `rst` asserted mid-word (after 2 bytes of r7): `tx_valid`, `dbg_on` and `busy` drop immediately. A new `start` begins again at r0 with byte 00.
- `tx_ready` held low for 1000 cycles at the first byte: `dbg_addr`=0 held, `tx_data`=0x00, `tx_valid`=1 throughout, and no `done`.
